// File: rtl/phy_init_multi_pkg.sv
// Shared definitions for the multi-PHY bring-up sequencer: strap layout,
// channel index width, sequencer states and a counter-width helper.
// No ports; imported by the interface, the arbiter and the top.
package gige_pkg;

  // Strap word layout: {addr[4:0], rx_dv, rxd[7:0]}
  localparam int STRAP_W  = 14;
  localparam int RXD_LSB  = 0;
  localparam int RXDV_BIT = 8;
  localparam int ADDR_LSB = 9;

  localparam int MAX_NUM_PHY = 8;
  localparam int CHAN_W      = $clog2(MAX_NUM_PHY);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ASSERT = 3'd1,
    ST_HOLD   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Width of a down-counter that must be able to hold the largest phase length.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/phy_init_multi_if.sv
// Bundle between the board top level / datapath and the PHY init sequencer.
// Ports: strap_cfg, restart (into the sequencer); phy_hw_rst, strap_out,
// strap_oe, phy_ready, busy, active_chan (out of the sequencer).
interface phy_init_multi_if #(
  parameter int NUM_PHY = 2
) ();
  import gige_pkg::*;

  logic [NUM_PHY*STRAP_W-1:0] strap_cfg;
  logic [NUM_PHY-1:0]         restart;
  logic [NUM_PHY-1:0]         phy_hw_rst;
  logic [NUM_PHY*STRAP_W-1:0] strap_out;
  logic [NUM_PHY-1:0]         strap_oe;
  logic [NUM_PHY-1:0]         phy_ready;
  logic                       busy;
  logic [CHAN_W-1:0]          active_chan;

  // master: the sequencer
  modport master (
    input  strap_cfg, restart,
    output phy_hw_rst, strap_out, strap_oe, phy_ready, busy, active_chan
  );

  // slave: the board / datapath side
  modport slave (
    output strap_cfg, restart,
    input  phy_hw_rst, strap_out, strap_oe, phy_ready, busy, active_chan
  );

endinterface

// File: rtl/phy_init_multi_rr_arb.sv
// Combinational round-robin pick of the next pending PHY channel, starting
// the search at last_served+1 and wrapping modulo NUM_PHY.
// Ports: pending, last_served in; grant, grant_vld out.
module phy_rr_arb
  import gige_pkg::*;
#(
  parameter int NUM_PHY = 2
) (
  input  logic [NUM_PHY-1:0] pending,
  input  logic [CHAN_W-1:0]  last_served,
  output logic [CHAN_W-1:0]  grant,
  output logic               grant_vld
);

  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    // Wrap-around candidates (at or below last_served) are considered first;
    // the second loop lets any pending channel above last_served override them.
    // Both loops run downward so the lowest index in each group wins.
    for (int j = NUM_PHY - 1; j >= 0; j--) begin
      if (pending[j] && (CHAN_W'(j) <= last_served)) begin
        grant     = CHAN_W'(j);
        grant_vld = 1'b1;
      end
    end
    for (int j = NUM_PHY - 1; j >= 0; j--) begin
      if (pending[j] && (CHAN_W'(j) > last_served)) begin
        grant     = CHAN_W'(j);
        grant_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/phy_init_multi.sv
// Bring-up sequencer for NUM_PHY PHYs: per channel, drives straps around a
// hardware reset pulse, one channel at a time in round-robin order.
// Ports: clk_50, reset (sync, active high), bus (master modport) carrying
// strap_cfg/restart in and phy_hw_rst/strap_out/strap_oe/phy_ready/busy/active_chan out.
module phy_init_multi
  import gige_pkg::*;
#(
  parameter int NUM_PHY       = 2,
  parameter int RST_CYCLES    = 500000,
  parameter int HOLD_CYCLES   = 50,
  parameter int SETTLE_CYCLES = 250000
) (
  input logic               clk_50,
  input logic               reset,
  phy_init_multi_if.master  bus
);

  localparam int CNT_W = cnt_width(RST_CYCLES, HOLD_CYCLES, SETTLE_CYCLES);
  localparam logic [CNT_W-1:0]  RST_LD    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  HOLD_LD   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
  // Starting last_served at the top channel makes channel 0 the first pick.
  localparam logic [CHAN_W-1:0] LAST_RST  = CHAN_W'(NUM_PHY - 1);

  state_t                     state, state_nxt;
  logic [CNT_W-1:0]           cnt, cnt_nxt;
  logic [CHAN_W-1:0]          act, act_nxt;
  logic [CHAN_W-1:0]          last_served, last_nxt;
  logic [STRAP_W-1:0]         latch, latch_nxt;
  logic [NUM_PHY-1:0]         pending, pending_nxt;
  logic [NUM_PHY-1:0]         ready, ready_nxt;
  logic [NUM_PHY-1:0]         restart_eff, pend_clr, rdy_set;

  logic [NUM_PHY-1:0]         hw_rst_q, hw_rst_nxt;
  logic [NUM_PHY-1:0]         oe_q, oe_nxt;
  logic [NUM_PHY*STRAP_W-1:0] so_q, so_nxt;
  logic                       busy_q, busy_nxt;

  logic [CHAN_W-1:0]          grant;
  logic                       grant_vld;

  phy_rr_arb #(.NUM_PHY(NUM_PHY)) u_arb (
    .pending     (pending),
    .last_served (last_served),
    .grant       (grant),
    .grant_vld   (grant_vld)
  );

  // State and output registers. Outputs are registered from the next-state
  // view so that they line up with the state they describe.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      act         <= '0;
      last_served <= LAST_RST;
      latch       <= '0;
      pending     <= '1;
      ready       <= '0;
      hw_rst_q    <= '0;
      oe_q        <= '0;
      so_q        <= '0;
      busy_q      <= 1'b1;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      act         <= act_nxt;
      last_served <= last_nxt;
      latch       <= latch_nxt;
      pending     <= pending_nxt;
      ready       <= ready_nxt;
      hw_rst_q    <= hw_rst_nxt;
      oe_q        <= oe_nxt;
      so_q        <= so_nxt;
      busy_q      <= busy_nxt;
    end
  end

  // Next-state, counter, pending and ready bookkeeping.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    act_nxt     = act;
    last_nxt    = last_served;
    latch_nxt   = latch;
    pend_clr    = '0;
    rdy_set     = '0;
    restart_eff = bus.restart;

    case (state)
      ST_IDLE: begin
        if (grant_vld) begin
          state_nxt = ST_ASSERT;
          cnt_nxt   = RST_LD;
          act_nxt   = grant;
          last_nxt  = grant;
          latch_nxt = bus.strap_cfg[int'(grant)*STRAP_W +: STRAP_W];
          for (int i = 0; i < NUM_PHY; i++) begin
            if (CHAN_W'(i) == grant) pend_clr[i] = 1'b1;
          end
        end
      end
      ST_ASSERT: begin
        if (cnt == '0) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = HOLD_LD;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (cnt == '0) begin
          state_nxt = ST_SETTLE;
          cnt_nxt   = SETTLE_LD;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      ST_SETTLE: begin
        if (cnt == '0) begin
          state_nxt = ST_DONE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
        for (int i = 0; i < NUM_PHY; i++) begin
          if (CHAN_W'(i) == act) rdy_set[i] = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // A channel in ASSERT is already being reset, so a restart for it is dropped.
    if (state == ST_ASSERT) begin
      for (int i = 0; i < NUM_PHY; i++) begin
        if (CHAN_W'(i) == act) restart_eff[i] = 1'b0;
      end
    end

    // A restart arriving on the pick edge wins over the pick's clear.
    pending_nxt = (pending & ~pend_clr) | restart_eff;
    // Pending always forces ready low, including over the DONE set.
    ready_nxt   = (ready | rdy_set) & ~pending_nxt;
  end

  // Pad and status outputs derived from the next state.
  always_comb begin
    hw_rst_nxt = '0;
    oe_nxt     = '0;
    so_nxt     = '0;
    for (int i = 0; i < NUM_PHY; i++) begin
      if ((state_nxt != ST_IDLE) && (act_nxt == CHAN_W'(i))) begin
        hw_rst_nxt[i] = (state_nxt != ST_ASSERT);
        oe_nxt[i]     = (state_nxt == ST_ASSERT) || (state_nxt == ST_HOLD);
        if ((state_nxt == ST_ASSERT) || (state_nxt == ST_HOLD)) begin
          so_nxt[i*STRAP_W +: STRAP_W] = latch_nxt;
        end
      end else begin
        // Waiting channels sit in reset; finished channels run.
        hw_rst_nxt[i] = ~pending_nxt[i];
      end
    end
    busy_nxt = (state_nxt != ST_IDLE) || (|pending_nxt);
  end

  assign bus.phy_hw_rst  = hw_rst_q;
  assign bus.strap_oe    = oe_q;
  assign bus.strap_out   = so_q;
  assign bus.phy_ready   = ready;
  assign bus.busy        = busy_q;
  assign bus.active_chan = act;

endmodule
